// File: rtl/pipe_front_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_front_regs : PC, IF/ID and ID/EX pipeline state plus hazard counters.
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_front_regs #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int unsigned      CTRL_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F_stall_i,
  input  logic              D_stall_i,
  input  logic              D_flush_i,
  input  logic              E_flush_i,
  input  logic [XLEN-1:0]   F_pc_next_i,
  input  logic [31:0]       F_instr_i,
  input  logic [XLEN-1:0]   F_pc_plus4_i,
  output logic [XLEN-1:0]   F_pc_o,
  output logic [31:0]       D_instr_o,
  output logic [XLEN-1:0]   D_pc_o,
  output logic [XLEN-1:0]   D_pc_plus4_o,
  output logic              D_valid_o,
  output logic [4:0]        D_rf_a1_o,
  output logic [4:0]        D_rf_a2_o,
  output logic [4:0]        D_rf_a3_o,
  input  logic [XLEN-1:0]   D_rd1_i,
  input  logic [XLEN-1:0]   D_rd2_i,
  input  logic [XLEN-1:0]   D_imm_i,
  input  logic [CTRL_W-1:0] D_ctrl_i,
  output logic [XLEN-1:0]   E_rd1_o,
  output logic [XLEN-1:0]   E_rd2_o,
  output logic [XLEN-1:0]   E_imm_o,
  output logic [XLEN-1:0]   E_pc_o,
  output logic [XLEN-1:0]   E_pc_plus4_o,
  output logic [4:0]        E_rf_a1_o,
  output logic [4:0]        E_rf_a2_o,
  output logic [4:0]        E_rf_a3_o,
  output logic [CTRL_W-1:0] E_ctrl_o,
  output logic              E_valid_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [XLEN-1:0]   F_pc_q, F_pc_d;
  logic [31:0]       D_instr_q, D_instr_d;
  logic [XLEN-1:0]   D_pc_q, D_pc_d;
  logic [XLEN-1:0]   D_pc_plus4_q, D_pc_plus4_d;
  logic              D_valid_q, D_valid_d;
  logic [XLEN-1:0]   E_rd1_q, E_rd1_d;
  logic [XLEN-1:0]   E_rd2_q, E_rd2_d;
  logic [XLEN-1:0]   E_imm_q, E_imm_d;
  logic [XLEN-1:0]   E_pc_q, E_pc_d;
  logic [XLEN-1:0]   E_pc_plus4_q, E_pc_plus4_d;
  logic [4:0]        E_rf_a1_q, E_rf_a1_d;
  logic [4:0]        E_rf_a2_q, E_rf_a2_d;
  logic [4:0]        E_rf_a3_q, E_rf_a3_d;
  logic [CTRL_W-1:0] E_ctrl_q, E_ctrl_d;
  logic              E_valid_q, E_valid_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;

  logic [4:0]        D_rf_a1_w, D_rf_a2_w, D_rf_a3_w;

  assign D_rf_a1_w = D_instr_q[19:15];
  assign D_rf_a2_w = D_instr_q[24:20];
  assign D_rf_a3_w = D_instr_q[11:7];

  // A taken redirect must never be lost behind a simultaneous load-use stall.
  always_comb begin
    F_pc_d = F_pc_q;
    if (!F_stall_i || D_flush_i) begin
      F_pc_d = F_pc_next_i;
    end
  end

  always_comb begin
    D_instr_d    = D_instr_q;
    D_pc_d       = D_pc_q;
    D_pc_plus4_d = D_pc_plus4_q;
    D_valid_d    = D_valid_q;
    if (D_flush_i) begin
      D_instr_d    = NOP_INSTR;
      D_pc_d       = '0;
      D_pc_plus4_d = '0;
      D_valid_d    = 1'b0;
    end else if (!D_stall_i) begin
      D_instr_d    = F_instr_i;
      D_pc_d       = F_pc_q;
      D_pc_plus4_d = F_pc_plus4_i;
      D_valid_d    = 1'b1;
    end
  end

  always_comb begin
    E_rd1_d      = D_rd1_i;
    E_rd2_d      = D_rd2_i;
    E_imm_d      = D_imm_i;
    E_pc_d       = D_pc_q;
    E_pc_plus4_d = D_pc_plus4_q;
    E_rf_a1_d    = D_rf_a1_w;
    E_rf_a2_d    = D_rf_a2_w;
    E_rf_a3_d    = D_rf_a3_w;
    E_ctrl_d     = D_ctrl_i;
    E_valid_d    = D_valid_q;
    if (E_flush_i) begin
      E_rd1_d      = '0;
      E_rd2_d      = '0;
      E_imm_d      = '0;
      E_pc_d       = '0;
      E_pc_plus4_d = '0;
      E_rf_a1_d    = '0;
      E_rf_a2_d    = '0;
      E_rf_a3_d    = '0;
      E_ctrl_d     = '0;
      E_valid_d    = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (F_stall_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (D_flush_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F_pc_q       <= RESET_PC;
      D_instr_q    <= NOP_INSTR;
      D_pc_q       <= '0;
      D_pc_plus4_q <= '0;
      D_valid_q    <= 1'b0;
      E_rd1_q      <= '0;
      E_rd2_q      <= '0;
      E_imm_q      <= '0;
      E_pc_q       <= '0;
      E_pc_plus4_q <= '0;
      E_rf_a1_q    <= '0;
      E_rf_a2_q    <= '0;
      E_rf_a3_q    <= '0;
      E_ctrl_q     <= '0;
      E_valid_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      F_pc_q       <= F_pc_d;
      D_instr_q    <= D_instr_d;
      D_pc_q       <= D_pc_d;
      D_pc_plus4_q <= D_pc_plus4_d;
      D_valid_q    <= D_valid_d;
      E_rd1_q      <= E_rd1_d;
      E_rd2_q      <= E_rd2_d;
      E_imm_q      <= E_imm_d;
      E_pc_q       <= E_pc_d;
      E_pc_plus4_q <= E_pc_plus4_d;
      E_rf_a1_q    <= E_rf_a1_d;
      E_rf_a2_q    <= E_rf_a2_d;
      E_rf_a3_q    <= E_rf_a3_d;
      E_ctrl_q     <= E_ctrl_d;
      E_valid_q    <= E_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign F_pc_o       = F_pc_q;
  assign D_instr_o    = D_instr_q;
  assign D_pc_o       = D_pc_q;
  assign D_pc_plus4_o = D_pc_plus4_q;
  assign D_valid_o    = D_valid_q;
  assign D_rf_a1_o    = D_rf_a1_w;
  assign D_rf_a2_o    = D_rf_a2_w;
  assign D_rf_a3_o    = D_rf_a3_w;
  assign E_rd1_o      = E_rd1_q;
  assign E_rd2_o      = E_rd2_q;
  assign E_imm_o      = E_imm_q;
  assign E_pc_o       = E_pc_q;
  assign E_pc_plus4_o = E_pc_plus4_q;
  assign E_rf_a1_o    = E_rf_a1_q;
  assign E_rf_a2_o    = E_rf_a2_q;
  assign E_rf_a3_o    = E_rf_a3_q;
  assign E_ctrl_o     = E_ctrl_q;
  assign E_valid_o    = E_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_front_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_front_regs : directed table, corner sequences and randomized model check.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_front_regs;

  logic        clk;
  logic        rst;
  logic        F_stall, D_stall, D_flush, E_flush;
  logic [31:0] F_pc_next, F_instr, F_pc_plus4;
  logic [31:0] F_pc, D_instr, D_pc, D_pc_plus4;
  logic        D_valid;
  logic [4:0]  D_rf_a1, D_rf_a2, D_rf_a3;
  logic [31:0] D_rd1, D_rd2, D_imm;
  logic [11:0] D_ctrl;
  logic [31:0] E_rd1, E_rd2, E_imm, E_pc, E_pc_plus4;
  logic [4:0]  E_rf_a1, E_rf_a2, E_rf_a3;
  logic [11:0] E_ctrl;
  logic        E_valid;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_front_regs dut (
    .clk(clk), .rst(rst),
    .F_stall_i(F_stall), .D_stall_i(D_stall), .D_flush_i(D_flush), .E_flush_i(E_flush),
    .F_pc_next_i(F_pc_next), .F_instr_i(F_instr), .F_pc_plus4_i(F_pc_plus4),
    .F_pc_o(F_pc), .D_instr_o(D_instr), .D_pc_o(D_pc), .D_pc_plus4_o(D_pc_plus4),
    .D_valid_o(D_valid), .D_rf_a1_o(D_rf_a1), .D_rf_a2_o(D_rf_a2), .D_rf_a3_o(D_rf_a3),
    .D_rd1_i(D_rd1), .D_rd2_i(D_rd2), .D_imm_i(D_imm), .D_ctrl_i(D_ctrl),
    .E_rd1_o(E_rd1), .E_rd2_o(E_rd2), .E_imm_o(E_imm), .E_pc_o(E_pc),
    .E_pc_plus4_o(E_pc_plus4), .E_rf_a1_o(E_rf_a1), .E_rf_a2_o(E_rf_a2),
    .E_rf_a3_o(E_rf_a3), .E_ctrl_o(E_ctrl), .E_valid_o(E_valid),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed table: one row per edge; expectations worked out by hand.
  typedef struct {
    logic        rst, fs, ds, dfl, efl;
    logic [31:0] pc_next;
    logic [31:0] e_fpc, e_dinstr, e_dpc;
    logic        e_dvalid;
    logic [31:0] e_epc;
    logic        e_evalid;
    logic [11:0] e_ectrl;
    logic [31:0] e_stall, e_flush;
  } vec_t;

  vec_t vt[14];

  // Higher-level model: stage records advanced by the hazard rules.
  typedef struct {
    logic [31:0] instr, pc, pc4;
    logic        valid;
  } dstage_t;
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  a1, a2, a3;
    logic [11:0] ctrl;
    logic        valid;
  } estage_t;

  logic [31:0]     m_pc;
  dstage_t         m_d;
  estage_t         m_e;
  longint unsigned m_stall, m_flush;

  function automatic dstage_t d_bubble();
    dstage_t r;
    r.instr = 32'h0000_0013; r.pc = '0; r.pc4 = '0; r.valid = 1'b0;
    return r;
  endfunction

  function automatic estage_t e_bubble();
    estage_t r;
    r.rd1 = '0; r.rd2 = '0; r.imm = '0; r.pc = '0; r.pc4 = '0;
    r.a1 = '0; r.a2 = '0; r.a3 = '0; r.ctrl = '0; r.valid = 1'b0;
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] n_pc;
    dstage_t     n_d;
    estage_t     n_e;
    if (rst) begin
      m_pc = 32'h0; m_d = d_bubble(); m_e = e_bubble(); m_stall = 0; m_flush = 0;
      return;
    end
    n_pc = (D_flush || !F_stall) ? F_pc_next : m_pc;
    if (D_flush) n_d = d_bubble();
    else if (D_stall) n_d = m_d;
    else begin
      n_d.instr = F_instr; n_d.pc = m_pc; n_d.pc4 = F_pc_plus4; n_d.valid = 1'b1;
    end
    if (E_flush) n_e = e_bubble();
    else begin
      n_e.rd1 = D_rd1; n_e.rd2 = D_rd2; n_e.imm = D_imm;
      n_e.pc = m_d.pc; n_e.pc4 = m_d.pc4;
      n_e.a1 = m_d.instr[19:15]; n_e.a2 = m_d.instr[24:20]; n_e.a3 = m_d.instr[11:7];
      n_e.ctrl = D_ctrl; n_e.valid = m_d.valid;
    end
    if (F_stall) m_stall = (m_stall + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall + 1;
    if (D_flush) m_flush = (m_flush + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_flush + 1;
    m_pc = n_pc; m_d = n_d; m_e = n_e;
  endtask

  task automatic check_model();
    chk("rnd F_pc", F_pc, m_pc);
    chk("rnd D_instr", D_instr, m_d.instr);
    chk("rnd D_pc", D_pc, m_d.pc);
    chk("rnd D_pc_plus4", D_pc_plus4, m_d.pc4);
    chk("rnd D_valid", D_valid, m_d.valid);
    chk("rnd D_rf_a", {D_rf_a1, D_rf_a2, D_rf_a3}, {m_d.instr[19:15], m_d.instr[24:20], m_d.instr[11:7]});
    chk("rnd E_data", {E_rd1, E_rd2}, {m_e.rd1, m_e.rd2});
    chk("rnd E_imm", E_imm, m_e.imm);
    chk("rnd E_pc", {E_pc, E_pc_plus4}, {m_e.pc, m_e.pc4});
    chk("rnd E_rf_a", {E_rf_a1, E_rf_a2, E_rf_a3}, {m_e.a1, m_e.a2, m_e.a3});
    chk("rnd E_ctrl", E_ctrl, m_e.ctrl);
    chk("rnd E_valid", E_valid, m_e.valid);
    chk("rnd stall_cnt", stall_cnt, m_stall);
    chk("rnd flush_cnt", flush_cnt, m_flush);
  endtask

  function automatic vec_t mk(input logic r, fs, ds, dfl, efl, input logic [31:0] nx,
                              input logic [31:0] fpc, dins, dpc, input logic dv,
                              input logic [31:0] epc, input logic ev, input logic [11:0] ectl,
                              input logic [31:0] sc, fc);
    vec_t v;
    v.rst = r; v.fs = fs; v.ds = ds; v.dfl = dfl; v.efl = efl; v.pc_next = nx;
    v.e_fpc = fpc; v.e_dinstr = dins; v.e_dpc = dpc; v.e_dvalid = dv;
    v.e_epc = epc; v.e_evalid = ev; v.e_ectrl = ectl; v.e_stall = sc; v.e_flush = fc;
    return v;
  endfunction

  initial begin
    logic [31:0] cur_pc;
    int          sel;

    vt[0]  = mk(1,1,1,1,1, 32'h1234, 32'h0,   32'h13,        32'h0,   0, 32'h0,  0, 12'h0,   0, 0);
    vt[1]  = mk(1,1,1,1,1, 32'h5678, 32'h0,   32'h13,        32'h0,   0, 32'h0,  0, 12'h0,   0, 0);
    vt[2]  = mk(0,0,0,0,0, 32'h4,    32'h4,   32'hA500_0000, 32'h0,   1, 32'h0,  0, 12'hABC, 0, 0);
    vt[3]  = mk(0,0,0,0,0, 32'h8,    32'h8,   32'hA500_0004, 32'h4,   1, 32'h0,  1, 12'hABC, 0, 0);
    vt[4]  = mk(0,0,0,0,0, 32'hC,    32'hC,   32'hA500_0008, 32'h8,   1, 32'h4,  1, 12'hABC, 0, 0);
    vt[5]  = mk(0,0,0,0,0, 32'h10,   32'h10,  32'hA500_000C, 32'hC,   1, 32'h8,  1, 12'hABC, 0, 0);
    vt[6]  = mk(0,0,0,0,0, 32'h14,   32'h14,  32'hA500_0010, 32'h10,  1, 32'hC,  1, 12'hABC, 0, 0);
    vt[7]  = mk(0,1,1,0,1, 32'h18,   32'h14,  32'hA500_0010, 32'h10,  1, 32'h0,  0, 12'h0,   1, 0);
    vt[8]  = mk(0,0,0,0,0, 32'h18,   32'h18,  32'hA500_0014, 32'h14,  1, 32'h10, 1, 12'hABC, 1, 0);
    vt[9]  = mk(0,1,1,1,1, 32'h100,  32'h100, 32'h13,        32'h0,   0, 32'h0,  0, 12'h0,   2, 1);
    vt[10] = mk(0,0,0,0,0, 32'h104,  32'h104, 32'hA500_0100, 32'h100, 1, 32'h0,  0, 12'hABC, 2, 1);
    vt[11] = mk(0,0,0,0,0, 32'h108,  32'h108, 32'hA500_0104, 32'h104, 1, 32'h100,1, 12'hABC, 2, 1);
    vt[12] = mk(1,1,1,0,0, 32'h200,  32'h0,   32'h13,        32'h0,   0, 32'h0,  0, 12'h0,   0, 0);
    vt[13] = mk(0,0,0,0,0, 32'h300,  32'h300, 32'hA500_0000, 32'h0,   1, 32'h0,  0, 12'hABC, 0, 0);

    rst = 1; F_stall = 0; D_stall = 0; D_flush = 0; E_flush = 0;
    F_pc_next = 0; F_instr = 0; F_pc_plus4 = 0;
    D_rd1 = 32'h1111_1111; D_rd2 = 32'h2222_2222; D_imm = 32'h3333_3333; D_ctrl = 12'hABC;
    cur_pc = 32'h0;

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; F_stall = vt[i].fs; D_stall = vt[i].ds;
      D_flush = vt[i].dfl; E_flush = vt[i].efl; F_pc_next = vt[i].pc_next;
      F_instr = 32'hA500_0000 | cur_pc; F_pc_plus4 = cur_pc + 32'd4;
      step();
      chk($sformatf("vec%0d F_pc", i), F_pc, vt[i].e_fpc);
      chk($sformatf("vec%0d D_instr", i), D_instr, vt[i].e_dinstr);
      chk($sformatf("vec%0d D_pc", i), D_pc, vt[i].e_dpc);
      chk($sformatf("vec%0d D_valid", i), D_valid, vt[i].e_dvalid);
      chk($sformatf("vec%0d E_pc", i), E_pc, vt[i].e_epc);
      chk($sformatf("vec%0d E_valid", i), E_valid, vt[i].e_evalid);
      chk($sformatf("vec%0d E_ctrl", i), E_ctrl, vt[i].e_ectrl);
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, vt[i].e_stall);
      chk($sformatf("vec%0d flush_cnt", i), flush_cnt, vt[i].e_flush);
      cur_pc = vt[i].e_fpc;
    end

    // Saturation: preload the stall counter just below its ceiling.
    F_stall = 0; D_stall = 0; D_flush = 0; E_flush = 0; rst = 0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("sat preload", stall_cnt, 32'hFFFF_FFFE);
    F_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("sat cycle%0d", k), stall_cnt, 32'hFFFF_FFFF);
    end

    // Reset while stalled, then the first free edge loads F_pc_next.
    rst = 1; F_stall = 1; D_stall = 1; F_pc_next = 32'h444;
    step();
    chk("rst-stall F_pc", F_pc, 32'h0);
    chk("rst-stall stall_cnt", stall_cnt, 32'h0);
    chk("rst-stall D_instr", D_instr, 32'h13);
    rst = 0; F_stall = 0; D_stall = 0;
    step();
    chk("post-rst F_pc", F_pc, 32'h444);

    // Randomized run against the stage model.
    rst = 1;
    model_edge();
    step();
    check_model();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 3);
      sel = $urandom_range(0, 99);
      {F_stall, D_stall, D_flush, E_flush} = 4'b0000;
      if (sel >= 60 && sel < 75) {F_stall, D_stall, E_flush} = 3'b111;
      else if (sel >= 75 && sel < 90) begin
        {D_flush, E_flush} = 2'b11;
        {F_stall, D_stall} = 2'($urandom_range(0, 3));
      end else if (sel >= 90) {F_stall, D_stall, D_flush, E_flush} = 4'($urandom_range(0, 15));
      F_pc_next  = (sel >= 75 && sel < 90) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
      F_instr    = $urandom;
      F_pc_plus4 = m_pc + 32'd4;
      D_rd1 = $urandom; D_rd2 = $urandom; D_imm = $urandom;
      D_ctrl = 12'($urandom);
      model_edge();
      step();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
